// File: rtl/serial_approx_subtractor.sv
// Bit-serial N-bit subtractor, LSB first: Diff = A - B - Bin, with an approximate
// borrow cell in the low APPROX_BITS positions; valid/ready handshake on both sides.
module serial_approx_subtractor #(
    parameter int N           = 8,
    parameter int APPROX_BITS = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic         Bout,
    output logic         busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          borrow_q, borrow_d;
    logic          bout_q, bout_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic bit_a, bit_b, bit_d, bit_bo;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;

        bit_a = a_q[cnt_q];
        bit_b = b_q[cnt_q];
        bit_d = bit_a ^ bit_b ^ borrow_q;
        // Approximate cell drops the borrow-in term from the borrow-out only.
        if (int'(cnt_q) < APPROX_BITS) begin
            bit_bo = ~bit_a & bit_b;
        end else begin
            bit_bo = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                diff_d[cnt_q] = bit_d;
                borrow_d      = bit_bo;
                if (cnt_q == CW'(N - 1)) begin
                    bout_d  = bit_bo;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                // First DONE cycle raises out_valid; the handshake is taken once it is visible.
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = valid_q;
    assign Diff      = diff_q;
    assign Bout      = bout_q;

endmodule

// File: tb/tb_serial_approx_subtractor.sv
// Self-checking bench: directed scenarios plus a randomised stream checked against
// an A-B-Bin scoreboard; a second instance covers the approximate cells.
module tb_serial_approx_subtractor;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, bin, bout, busy;
    logic [N-1:0] a, b, diff;
    logic         in_valid_x, in_ready_x, out_valid_x, out_ready_x, bin_x, bout_x, busy_x;
    logic [N-1:0] a_x, b_x, diff_x;

    int checks = 0;
    int errors = 0;
    logic [N:0] sb[$];

    always #5 clk = ~clk;

    serial_approx_subtractor #(.N(N), .APPROX_BITS(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .Bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .Diff(diff), .Bout(bout), .busy(busy)
    );

    serial_approx_subtractor #(.N(N), .APPROX_BITS(2)) dut_x (
        .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready_x),
        .A(a_x), .B(b_x), .Bin(bin_x), .out_valid(out_valid_x), .out_ready(out_ready_x),
        .Diff(diff_x), .Bout(bout_x), .busy(busy_x)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi);
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    task automatic accept;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({out_valid, in_ready, busy, bout, diff} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs got={ov,ir,busy,bout,diff}=%b expected=0100_00000000",
                     {out_valid, in_ready, busy, bout, diff});
        end
        checks++;
        if ({out_valid_x, in_ready_x, busy_x, bout_x, diff_x} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs_x got=%b expected=0100_00000000",
                     {out_valid_x, in_ready_x, busy_x, bout_x, diff_x});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got in_ready=%b busy=%b expected in_ready=1 busy=0", in_ready, busy);
        end
    endtask

    task automatic test_basic;
        int cyc;
        start_op(8'h50, 8'h23, 1'b0);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_run got busy=%b in_ready=%b expected busy=1 in_ready=0", busy, in_ready);
        end
        wait_valid(cyc);
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL basic_latency got=%0d expected=9", cyc);
        end
        checks++;
        if ({bout, diff} !== {1'b0, 8'h2D}) begin
            errors++;
            $display("FAIL basic_result got Bout=%b Diff=%h expected Bout=0 Diff=2d", bout, diff);
        end
        accept();
        checks++;
        if ({out_valid, in_ready, busy, diff} !== {1'b0, 1'b1, 1'b0, 8'h2D}) begin
            errors++;
            $display("FAIL basic_after_accept got ov=%b ir=%b busy=%b Diff=%h expected 0 1 0 2d",
                     out_valid, in_ready, busy, diff);
        end
    endtask

    task automatic test_borrow_ripple;
        int cyc;
        start_op(8'h00, 8'h00, 1'b1);
        wait_valid(cyc);
        checks++;
        if ({bout, diff} !== {1'b1, 8'hFF} || cyc !== 9) begin
            errors++;
            $display("FAIL borrow_ripple got Bout=%b Diff=%h cyc=%0d expected Bout=1 Diff=ff cyc=9", bout, diff, cyc);
        end
        accept();
    endtask

    task automatic test_approx;
        int cyc;
        a_x = 8'h02; b_x = 8'h03; bin_x = 1'b0; in_valid_x = 1'b1;
        tick();
        in_valid_x = 1'b0;
        cyc = 0;
        while (!out_valid_x && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++;
        if ({bout_x, diff_x} !== {1'b0, 8'h03} || cyc !== 9) begin
            errors++;
            $display("FAIL approx_result got Bout=%b Diff=%h cyc=%0d expected Bout=0 Diff=03 cyc=9", bout_x, diff_x, cyc);
        end
        out_ready_x = 1'b1;
        tick();
        out_ready_x = 1'b0;
        checks++;
        if (out_valid_x !== 1'b0 || in_ready_x !== 1'b1) begin
            errors++;
            $display("FAIL approx_accept got ov=%b ir=%b expected ov=0 ir=1", out_valid_x, in_ready_x);
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        start_op(8'hA5, 8'h3C, 1'b1);
        wait_valid(cyc);
        a = 8'hFF; b = 8'h00; bin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({out_valid, in_ready, bout, diff} !== {1'b1, 1'b0, 1'b0, 8'h68}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d] got ov=%b ir=%b Bout=%b Diff=%h expected 1 0 0 68",
                         i, out_valid, in_ready, bout, diff);
            end
        end
        in_valid = 1'b0;
        accept();
        checks++;
        if ({out_valid, busy, in_ready, diff} !== {1'b0, 1'b0, 1'b1, 8'h68}) begin
            errors++;
            $display("FAIL backpressure_release got ov=%b busy=%b ir=%b Diff=%h expected 0 0 1 68",
                     out_valid, busy, in_ready, diff);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        start_op(8'h77, 8'h11, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, busy, bout, diff} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid_run got={ov,ir,busy,bout,diff}=%b expected=0100_00000000",
                     {out_valid, in_ready, busy, bout, diff});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        start_op(8'h10, 8'h01, 1'b0);
        wait_valid(cyc);
        checks++;
        if ({bout, diff} !== {1'b0, 8'h0F} || cyc !== 9) begin
            errors++;
            $display("FAIL after_reset_op got Bout=%b Diff=%h cyc=%0d expected Bout=0 Diff=0f cyc=9", bout, diff, cyc);
        end
        accept();
    endtask

    task automatic test_back_to_back;
        fork
            begin : producer
                for (int n = 0; n < 1000; n++) begin
                    automatic logic [N-1:0] av = N'($urandom);
                    automatic logic [N-1:0] bv = N'($urandom);
                    automatic logic         bi = 1'($urandom);
                    automatic logic         hs = 1'b0;
                    automatic int           guard = 0;
                    repeat ($urandom_range(0, 3)) tick();
                    a = av; b = bv; bin = bi; in_valid = 1'b1;
                    do begin
                        hs = in_ready;
                        tick();
                        guard++;
                    end while (!hs && guard < 200);
                    in_valid = 1'b0;
                    if (hs) begin
                        sb.push_back({1'b0, av} - {1'b0, bv} - {8'h00, bi});
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL stream_in_timeout op=%0d got in_ready=0 expected in_ready=1", n);
                        break;
                    end
                end
            end
            begin : consumer
                automatic int received = 0;
                automatic int cyc = 0;
                automatic logic [N:0] exp_v;
                while (received < 1000 && cyc < 40000) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    if (out_valid && out_ready) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL stream_underflow got result Diff=%h with empty scoreboard expected none", diff);
                        end else begin
                            exp_v = sb.pop_front();
                            if ({bout, diff} !== exp_v) begin
                                errors++;
                                $display("FAIL stream_result[%0d] got Bout=%b Diff=%h expected Bout=%b Diff=%h",
                                         received, bout, diff, exp_v[N], exp_v[N-1:0]);
                            end
                        end
                        received++;
                    end
                    tick();
                    cyc++;
                end
                out_ready = 1'b0;
                checks++;
                if (received != 1000) begin
                    errors++;
                    $display("FAIL stream_count got=%0d expected=1000", received);
                end
            end
        join
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stream_leftover got=%0d expected=0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        in_valid_x = 1'b0; out_ready_x = 1'b0; a_x = '0; b_x = '0; bin_x = 1'b0;
        test_reset();
        test_basic();
        test_borrow_ripple();
        test_approx();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
